// File: rtl/sha256_pkg.sv
// SHA-256 shared constants and word functions.
// Used by the message-schedule generator and the compression round stage.
package sha256_pkg;

    // Round constants K[0..63] from FIPS 180-4.
    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value H(0), word 0 first.
    localparam logic [31:0] SHA256_H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] sha_rotr(
        input logic [31:0] x,
        input int unsigned n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    // Schedule sigma0: ROTR7 ^ ROTR18 ^ SHR3.
    function automatic logic [31:0] sha_sigma0(input logic [31:0] x);
        return sha_rotr(x, 7) ^ sha_rotr(x, 18) ^ (x >> 3);
    endfunction

    // Schedule sigma1: ROTR17 ^ ROTR19 ^ SHR10.
    function automatic logic [31:0] sha_sigma1(input logic [31:0] x);
        return sha_rotr(x, 17) ^ sha_rotr(x, 19) ^ (x >> 10);
    endfunction

    // Compression Sigma0: ROTR2 ^ ROTR13 ^ ROTR22.
    function automatic logic [31:0] sha_bsigma0(input logic [31:0] x);
        return sha_rotr(x, 2) ^ sha_rotr(x, 13) ^ sha_rotr(x, 22);
    endfunction

    // Compression Sigma1: ROTR6 ^ ROTR11 ^ ROTR25.
    function automatic logic [31:0] sha_bsigma1(input logic [31:0] x);
        return sha_rotr(x, 6) ^ sha_rotr(x, 11) ^ sha_rotr(x, 25);
    endfunction

    function automatic logic [31:0] sha_ch(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] sha_maj(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/wk_k_rom.sv
// Combinational round-constant lookup, index to K[index].
// Kept separate so unrolled round stages can instantiate their own copy.
module wk_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  index,
    output logic [31:0] k
);

    // Pure table lookup into the FIPS 180-4 constants.
    always_comb begin
        k = SHA256_K[index];
    end

endmodule

// File: rtl/wk_schedule_gen.sv
// SHA-256 message schedule generator: streams one (W[t], K[t]) per cycle.
// A 16-word sliding window expands the block on the fly ahead of the rounds.
module wk_schedule_gen
    import sha256_pkg::*;
#(
    parameter int WK_LENGTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [511:0]                 message_block,
    output logic [31:0]                  cur_w,
    output logic [31:0]                  cur_k,
    output logic [$clog2(WK_LENGTH)-1:0] wk_vector_index,
    output logic                         wk_index_complete
);

    localparam int IW = $clog2(WK_LENGTH);
    localparam logic [IW-1:0] LAST = IW'(WK_LENGTH - 1);

    logic [31:0]   win [0:15];
    logic [IW-1:0] idx;
    logic [31:0]   w_next;
    logic          at_last;
    logic [5:0]    k_index;

    assign at_last = (idx == LAST);

    // Next schedule word W[t+16] from the current window.
    always_comb begin
        w_next = sha_sigma1(win[14]) + win[9]
               + sha_sigma0(win[1]) + win[0];
    end

    // Window and round counter: load while idle, slide while running,
    // hold once the final round is reached.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            idx <= '0;
        end else if (!enable) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= message_block[511 - 32*i -: 32];
            end
            idx <= '0;
        end else if (!at_last) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= w_next;
            idx     <= idx + 1'b1;
        end
    end

    assign k_index = 6'(idx);

    wk_k_rom u_k_rom (
        .index (k_index),
        .k     (cur_k)
    );

    // Round outputs are straight views of the state.
    always_comb begin
        cur_w             = win[0];
        wk_vector_index   = idx;
        wk_index_complete = enable && at_last;
    end

endmodule

// File: tb/tb_wk_schedule_gen.sv
// Self-checking bench for wk_schedule_gen against a full-array
// schedule model and a software SHA-256 compression of the streamed pairs.
module tb_wk_schedule_gen;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [511:0] message_block = '0;
    logic [31:0]  cur_w;
    logic [31:0]  cur_k;
    logic [5:0]   wk_vector_index;
    logic         wk_index_complete;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_w [0:63];
    logic [31:0] got_w [0:63];
    logic [31:0] got_k [0:63];

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] HI [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] ABC_DIGEST [0:7] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    wk_schedule_gen #(.WK_LENGTH(64)) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .message_block     (message_block),
        .cur_w             (cur_w),
        .cur_k             (cur_k),
        .wk_vector_index   (wk_vector_index),
        .wk_index_complete (wk_index_complete)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-array expansion, straight from the textbook recurrence.
    task automatic model_expand(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // Load b while idle, raise enable, check t = 0..last_t.
    task automatic run_block(input logic [511:0] b, input int last_t, input string nm);
        model_expand(b);
        enable = 1'b0;
        message_block = b;
        step();
        enable = 1'b1;
        message_block = rand_block();
        #1;
        for (int t = 0; t <= last_t; t++) begin
            got_w[t] = cur_w;
            got_k[t] = cur_k;
            n_cmp++;
            if (cur_w !== exp_w[t] || cur_k !== KT[t] ||
                wk_vector_index !== 6'(t) || wk_index_complete !== (t == 63)) begin
                n_bad++;
                $display("FAIL %s t=%0d: got w=%h k=%h idx=%0d flag=%b, want w=%h k=%h idx=%0d flag=%b",
                         nm, t, cur_w, cur_k, wk_vector_index, wk_index_complete,
                         exp_w[t], KT[t], t, (t == 63));
            end
            if (t < last_t) step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        message_block = rand_block();
        step();
        step();
        n_cmp++;
        if (cur_w !== 32'h0 || cur_k !== 32'h428a2f98 ||
            wk_vector_index !== 6'd0 || wk_index_complete !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got w=%h k=%h idx=%0d flag=%b, want 0/428a2f98/0/0",
                     cur_w, cur_k, wk_vector_index, wk_index_complete);
        end
        reset = 1'b0;
    endtask

    task automatic test_abc();
        logic [511:0] b;
        logic [31:0] a, bb, c, d, e, f, g, h, t1, t2;
        logic [31:0] dig [0:7];
        logic [31:0] spot_w [0:3];
        int spot_t [0:3];
        b = '0;
        b[511:480] = 32'h61626380;
        b[31:0] = 32'h00000018;
        run_block(b, 63, "abc");
        spot_t = '{0, 15, 16, 17};
        spot_w = '{32'h61626380, 32'h00000018, 32'h61626380, 32'h000f0000};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_w[spot_t[i]] !== spot_w[i]) begin
                n_bad++;
                $display("FAIL abc_w%0d: got %h want %h", spot_t[i], got_w[spot_t[i]], spot_w[i]);
            end
        end
        n_cmp++;
        if (got_k[63] !== 32'hc67178f2 || wk_index_complete !== 1'b1) begin
            n_bad++;
            $display("FAIL abc_last: got k=%h flag=%b want c67178f2/1", got_k[63], wk_index_complete);
        end
        // Compress using the streamed (W, K) pairs and compare to the known digest.
        {a, bb, c, d, e, f, g, h} = {HI[0], HI[1], HI[2], HI[3], HI[4], HI[5], HI[6], HI[7]};
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g))
               + got_k[t] + got_w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = bb; bb = a; a = t1 + t2;
        end
        dig = '{HI[0] + a, HI[1] + bb, HI[2] + c, HI[3] + d,
                HI[4] + e, HI[5] + f, HI[6] + g, HI[7] + h};
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (dig[i] !== ABC_DIGEST[i]) begin
                n_bad++;
                $display("FAIL abc_digest%0d: got %h want %h", i, dig[i], ABC_DIGEST[i]);
            end
        end
    endtask

    // Assumes the previous task left the block in its last round.
    task automatic test_hold_last();
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (wk_vector_index !== 6'd63 || wk_index_complete !== 1'b1 ||
                cur_w !== exp_w[63] || cur_k !== KT[63]) begin
                n_bad++;
                $display("FAIL hold%0d: got idx=%0d flag=%b w=%h k=%h want 63/1/%h/%h",
                         i, wk_vector_index, wk_index_complete, cur_w, cur_k, exp_w[63], KT[63]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_abort();
        logic [511:0] b2;
        run_block(rand_block(), 20, "abort_pre");
        enable = 1'b0;
        #1;
        n_cmp++;
        if (wk_index_complete !== 1'b0 || wk_vector_index !== 6'd20) begin
            n_bad++;
            $display("FAIL abort_drop: got idx=%0d flag=%b want 20/0", wk_vector_index, wk_index_complete);
        end
        b2 = rand_block();
        message_block = b2;
        step();
        run_block(b2, 40, "abort_restart");
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        run_block(rand_block(), 30, "rst_pre");
        reset = 1'b1;
        step();
        n_cmp++;
        if (wk_vector_index !== 6'd0 || cur_w !== 32'h0 ||
            wk_index_complete !== 1'b0 || cur_k !== 32'h428a2f98) begin
            n_bad++;
            $display("FAIL reset_mid: got idx=%0d w=%h flag=%b k=%h want 0/0/0/428a2f98",
                     wk_vector_index, cur_w, wk_index_complete, cur_k);
        end
        reset = 1'b0;
        enable = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            run_block(rand_block(), 63, "b2b");
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_hold_last();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
